// File: rtl/cpu_reg_package.sv
// Shared definitions for the CPU bus arbiter: ownership state type and the
// default timing parameters used when the arbiter is instantiated bare.
package cpu_reg_package;

    // Default halt-to-grant settle delay, in cycles.
    localparam int unsigned SETTLE_CYCLES_DEFAULT  = 2;
    // Default cap on consecutive external-ownership cycles.
    localparam int unsigned MAX_BURST_DEFAULT      = 64;
    // Default number of CPU cycles guaranteed after the external master releases.
    localparam int unsigned CPU_MIN_CYCLES_DEFAULT = 8;

    // Bus ownership phases.
    typedef enum logic [1:0] {
        CPU_OWN   = 2'd0,
        HALT_REQ  = 2'd1,
        EXT_OWN   = 2'd2,
        EXT_DRAIN = 2'd3
    } arb_state_e;

endpackage

// File: rtl/cpu_bus_arbiter.sv
// CPU / external-master bus arbiter.
// The CPU owns the shared bus by default. An external request halts the CPU,
// waits SettleCycles for in-flight CPU activity to finish, then hands the bus
// to the external master until it drops its request. One drain cycle with
// writes suppressed follows, and the CPU is then protected from re-halting for
// CpuMinCycles cycles.
// Optional feature macro: ARB_BURST_LIMIT_EN -- when defined, external
// ownership is force-released after MaxBurst grant cycles.
module cpu_bus_arbiter
    import cpu_reg_package::*;
#(
    parameter int unsigned address_width = 32,
    parameter int unsigned data_width    = 32,
    parameter int unsigned SettleCycles  = SETTLE_CYCLES_DEFAULT,
    parameter int unsigned MaxBurst      = MAX_BURST_DEFAULT,
    parameter int unsigned CpuMinCycles  = CPU_MIN_CYCLES_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [address_width-1:0] cpu_address_i,
    input  logic [data_width-1:0]    cpu_data_i,
    input  logic                     cpu_we_i,
    input  logic [3:0]               cpu_we_ram_i,
    output logic                     cpu_halt_o,
    input  logic                     ext_req_i,
    output logic                     ext_gnt_o,
    input  logic [address_width-1:0] ext_address_i,
    input  logic [data_width-1:0]    ext_data_i,
    input  logic                     ext_we_i,
    input  logic [3:0]               ext_we_ram_i,
    input  logic                     ext_rd_i,
    output logic [data_width-1:0]    ext_rdata_o,
    output logic                     ext_rvalid_o,
    output logic [address_width-1:0] bus_address_o,
    output logic [data_width-1:0]    bus_data_o,
    output logic                     bus_we_o,
    output logic [3:0]               bus_we_ram_o,
    input  logic [data_width-1:0]    bus_rdata_i,
    output logic                     owner_o
);

    // Parameter range guards, evaluated at elaboration.
    generate
        if (SettleCycles < 1 || SettleCycles > 15) begin : g_bad_settle
            $error("cpu_bus_arbiter: SettleCycles must be 1..15");
        end
        if (MaxBurst < 1 || MaxBurst > 65535) begin : g_bad_burst
            $error("cpu_bus_arbiter: MaxBurst must be 1..65535");
        end
        if (CpuMinCycles > 255) begin : g_bad_cpumin
            $error("cpu_bus_arbiter: CpuMinCycles must be 0..255");
        end
    endgenerate

    localparam logic [3:0] SETTLE_LAST = 4'(SettleCycles - 1);
    localparam logic [7:0] CPU_MIN     = 8'(CpuMinCycles);

    arb_state_e               state_reg;
    arb_state_e               state_next;
    logic [3:0]               settle_cnt_reg;
    logic [7:0]               cool_cnt_reg;
    logic [address_width-1:0] last_cpu_addr_reg;
    logic                     rvalid_reg;
    logic [data_width-1:0]    rdata_hold_reg;
    logic                     cool_done;
    logic                     burst_done;

    // The cooldown is counted in CPU_OWN cycles: a request may be taken in the
    // cycle whose decrement brings the counter to zero, so exactly
    // CpuMinCycles CPU cycles separate a drain from the next halt.
    assign cool_done = (cool_cnt_reg <= 8'd1);

`ifdef ARB_BURST_LIMIT_EN
    localparam logic [15:0] BURST_LAST = 16'(MaxBurst - 1);
    logic [15:0] burst_cnt_reg;

    // Grant-cycle counter, restarted from 0 on every entry to EXT_OWN.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            burst_cnt_reg <= '0;
        end else if (state_reg != EXT_OWN) begin
            burst_cnt_reg <= '0;
        end else begin
            burst_cnt_reg <= burst_cnt_reg + 16'd1;
        end
    end

    assign burst_done = (burst_cnt_reg == BURST_LAST);
`else
    // No burst cap: ownership ends only when the external master lets go.
    assign burst_done = 1'b0;
`endif

    // Ownership sequencing.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            CPU_OWN:   if (ext_req_i && cool_done) state_next = HALT_REQ;
            HALT_REQ:  if (settle_cnt_reg == SETTLE_LAST) state_next = EXT_OWN;
            EXT_OWN:   if (!ext_req_i || burst_done) state_next = EXT_DRAIN;
            EXT_DRAIN: state_next = CPU_OWN;
            default:   state_next = CPU_OWN;
        endcase
    end

    // State register; reset drops straight back to CPU ownership.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg <= CPU_OWN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Settle counter runs only while halting and is ready at 0 on each entry.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            settle_cnt_reg <= '0;
        end else if (state_reg != HALT_REQ) begin
            settle_cnt_reg <= '0;
        end else begin
            settle_cnt_reg <= settle_cnt_reg + 4'd1;
        end
    end

    // Cooldown counter: loaded when the drain hands the bus back, then
    // decremented once per CPU_OWN cycle down to 0.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cool_cnt_reg <= '0;
        end else if (state_reg == EXT_DRAIN) begin
            cool_cnt_reg <= CPU_MIN;
        end else if (state_reg == CPU_OWN && cool_cnt_reg != 8'd0) begin
            cool_cnt_reg <= cool_cnt_reg - 8'd1;
        end
    end

    // Remember the CPU's final address so the bus stays put while it halts.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_cpu_addr_reg <= '0;
        end else if (state_reg == CPU_OWN) begin
            last_cpu_addr_reg <= cpu_address_i;
        end
    end

    // Bus mux and handshake outputs, decoded from the ownership state.
    always_comb begin
        bus_address_o = cpu_address_i;
        bus_data_o    = cpu_data_i;
        bus_we_o      = cpu_we_i;
        bus_we_ram_o  = cpu_we_ram_i;
        cpu_halt_o    = 1'b0;
        ext_gnt_o     = 1'b0;
        owner_o       = 1'b0;
        case (state_reg)
            HALT_REQ: begin
                bus_address_o = last_cpu_addr_reg;
                bus_we_o      = 1'b0;
                bus_we_ram_o  = 4'h0;
                cpu_halt_o    = 1'b1;
            end
            EXT_OWN: begin
                bus_address_o = ext_address_i;
                bus_data_o    = ext_data_i;
                bus_we_o      = ext_we_i;
                bus_we_ram_o  = ext_we_ram_i;
                cpu_halt_o    = 1'b1;
                ext_gnt_o     = 1'b1;
                owner_o       = 1'b1;
            end
            EXT_DRAIN: begin
                bus_address_o = ext_address_i;
                bus_data_o    = ext_data_i;
                bus_we_o      = 1'b0;
                bus_we_ram_o  = 4'h0;
                cpu_halt_o    = 1'b1;
                owner_o       = 1'b1;
            end
            default: ;
        endcase
    end

    // Read return tracking: a granted read strobe yields data the next cycle,
    // which may fall in the drain cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rvalid_reg <= 1'b0;
        end else begin
            rvalid_reg <= ext_gnt_o & ext_rd_i;
        end
    end

    // Hold the most recent returned word so ext_rdata_o is stable between reads.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rdata_hold_reg <= '0;
        end else if (rvalid_reg) begin
            rdata_hold_reg <= bus_rdata_i;
        end
    end

    // The bus read path is already registered, so returned data is forwarded
    // straight through in the valid cycle.
    assign ext_rvalid_o = rvalid_reg;
    assign ext_rdata_o  = rvalid_reg ? bus_rdata_i : rdata_hold_reg;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Scoreboard testbench for cpu_bus_arbiter. The stimulus process predicts each
// cycle's outputs from an ownership timeline model and queues them; a monitor
// pops and compares on the falling edge.
module tb_cpu_bus_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int SETTLE = 2;
    localparam int MAXB   = 4;
    localparam int CPUMIN = 8;
`ifdef ARB_BURST_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    localparam int R_CPU   = 0;
    localparam int R_HALT  = 1;
    localparam int R_GRANT = 2;
    localparam int R_DRAIN = 3;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic [AW-1:0] cpu_address_i;
    logic [DW-1:0] cpu_data_i;
    logic          cpu_we_i;
    logic [3:0]    cpu_we_ram_i;
    logic          cpu_halt_o;
    logic          ext_req_i;
    logic          ext_gnt_o;
    logic [AW-1:0] ext_address_i;
    logic [DW-1:0] ext_data_i;
    logic          ext_we_i;
    logic [3:0]    ext_we_ram_i;
    logic          ext_rd_i;
    logic [DW-1:0] ext_rdata_o;
    logic          ext_rvalid_o;
    logic [AW-1:0] bus_address_o;
    logic [DW-1:0] bus_data_o;
    logic          bus_we_o;
    logic [3:0]    bus_we_ram_o;
    logic [DW-1:0] bus_rdata_i;
    logic          owner_o;

    cpu_bus_arbiter #(
        .address_width(AW),
        .data_width   (DW),
        .SettleCycles (SETTLE),
        .MaxBurst     (MAXB),
        .CpuMinCycles (CPUMIN)
    ) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .cpu_address_i(cpu_address_i),
        .cpu_data_i   (cpu_data_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_we_ram_i (cpu_we_ram_i),
        .cpu_halt_o   (cpu_halt_o),
        .ext_req_i    (ext_req_i),
        .ext_gnt_o    (ext_gnt_o),
        .ext_address_i(ext_address_i),
        .ext_data_i   (ext_data_i),
        .ext_we_i     (ext_we_i),
        .ext_we_ram_i (ext_we_ram_i),
        .ext_rd_i     (ext_rd_i),
        .ext_rdata_o  (ext_rdata_o),
        .ext_rvalid_o (ext_rvalid_o),
        .bus_address_o(bus_address_o),
        .bus_data_o   (bus_data_o),
        .bus_we_o     (bus_we_o),
        .bus_we_ram_o (bus_we_ram_o),
        .bus_rdata_i  (bus_rdata_i),
        .owner_o      (owner_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int            role;
        int            cyc;
        bit            chk_addr;
        bit            chk_data;
        bit            chk_owner;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          we;
        logic [3:0]    we_ram;
        logic          halt;
        logic          gnt;
        logic          owner;
        logic          rvalid;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t exp_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Timeline model of bus ownership (cycle numbers since reset release).
    int            cyc;
    bit            in_ep;
    int            ep_start;
    int            grant_from;
    int            drain_at;
    int            free_from;
    logic [AW-1:0] last_cpu;
    bit            rv_pend;
    logic [DW-1:0] held_rdata;
    int            last_role;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        cyc        = 0;
        in_ep      = 1'b0;
        ep_start   = 0;
        grant_from = 0;
        drain_at   = -1;
        free_from  = 0;
        last_cpu   = '0;
        rv_pend    = 1'b0;
        held_rdata = '0;
        last_role  = R_CPU;
    endtask

    // Drive one cycle of inputs and queue the predicted outputs for it.
    task automatic drive_cycle(input logic req, input logic rd, input logic we,
                               input logic [3:0] we_ram, input logic [AW-1:0] eaddr,
                               input logic [DW-1:0] rdata);
        exp_t e;
        int   role;
        @(posedge clk_i);
        #1;
        ext_req_i     = req;
        ext_rd_i      = rd;
        ext_we_i      = we;
        ext_we_ram_i  = we_ram;
        ext_address_i = eaddr;
        ext_data_i    = $urandom;
        cpu_address_i = $urandom;
        cpu_data_i    = $urandom;
        cpu_we_i      = 1'($urandom);
        cpu_we_ram_i  = 4'($urandom);
        bus_rdata_i   = rdata;

        if (in_ep) begin
            if (cyc <= ep_start + SETTLE) begin
                role = R_HALT;
            end else if (drain_at < 0) begin
                role = R_GRANT;
                if (!req || (LIMIT_EN && (cyc - grant_from == MAXB - 1))) begin
                    drain_at = cyc + 1;
                    // At least CPUMIN (and never fewer than one) CPU cycles
                    // come between the drain and the next halt; the request is
                    // recognised in the cycle before that halt.
                    free_from = (drain_at + 1 + ((CPUMIN > 0) ? CPUMIN : 1)) - 1;
                end
            end else begin
                role  = R_DRAIN;
                in_ep = 1'b0;
            end
        end else begin
            role     = R_CPU;
            last_cpu = cpu_address_i;
            if (req && cyc >= free_from) begin
                in_ep      = 1'b1;
                ep_start   = cyc;
                grant_from = cyc + SETTLE + 1;
                drain_at   = -1;
            end
        end

        e.role      = role;
        e.cyc       = cyc;
        e.chk_addr  = (role != R_DRAIN);
        e.chk_data  = (role == R_CPU) || (role == R_GRANT);
        e.chk_owner = (role == R_CPU) || (role == R_GRANT);
        e.halt      = (role != R_CPU);
        e.gnt       = (role == R_GRANT);
        e.owner     = (role == R_GRANT);
        case (role)
            R_CPU: begin
                e.addr = cpu_address_i; e.data = cpu_data_i;
                e.we = cpu_we_i; e.we_ram = cpu_we_ram_i;
            end
            R_GRANT: begin
                e.addr = eaddr; e.data = ext_data_i;
                e.we = we; e.we_ram = we_ram;
            end
            R_HALT: begin
                e.addr = last_cpu; e.data = '0; e.we = 1'b0; e.we_ram = 4'h0;
            end
            default: begin
                e.addr = '0; e.data = '0; e.we = 1'b0; e.we_ram = 4'h0;
            end
        endcase

        e.rvalid = rv_pend;
        if (rv_pend) held_rdata = rdata;
        e.rdata = held_rdata;
        rv_pend = (role == R_GRANT) && rd;

        exp_q.push_back(e);
        last_role = role;
        cyc++;
    endtask

    // Monitor: compare the queued prediction against the DUT mid-cycle.
    initial begin
        exp_t m;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                m = exp_q.pop_front();
                chk("cpu_halt", cpu_halt_o, m.halt);
                chk("ext_gnt", ext_gnt_o, m.gnt);
                chk("bus_we", bus_we_o, m.we);
                chk("bus_we_ram", bus_we_ram_o, m.we_ram);
                chk("ext_rvalid", ext_rvalid_o, m.rvalid);
                chk("ext_rdata", ext_rdata_o, m.rdata);
                if (m.chk_addr)  chk("bus_address", bus_address_o, m.addr);
                if (m.chk_data)  chk("bus_data", bus_data_o, m.data);
                if (m.chk_owner) chk("owner", owner_o, m.owner);
                if (m.rvalid)
                    $display("cycle %0d: read return data=%08h", m.cyc, ext_rdata_o);
            end
        end
    end

    initial begin
        bit got;
        bit req_r;
        reset_n_i     = 1'b0;
        ext_req_i     = 1'b0;
        ext_rd_i      = 1'b0;
        ext_we_i      = 1'b0;
        ext_we_ram_i  = 4'h0;
        ext_address_i = '0;
        ext_data_i    = '0;
        cpu_address_i = 32'h1234_5678;
        cpu_data_i    = 32'hCAFE_0001;
        cpu_we_i      = 1'b1;
        cpu_we_ram_i  = 4'h3;
        bus_rdata_i   = '0;
        model_reset();

        // Reset state.
        repeat (3) @(negedge clk_i);
        chk("rst_halt", cpu_halt_o, 1'b0);
        chk("rst_gnt", ext_gnt_o, 1'b0);
        chk("rst_owner", owner_o, 1'b0);
        chk("rst_rvalid", ext_rvalid_o, 1'b0);
        chk("rst_rdata", ext_rdata_o, '0);
        chk("rst_bus_addr", bus_address_o, 32'h1234_5678);
        chk("rst_bus_we_ram", bus_we_ram_o, 4'h3);
        #1 reset_n_i = 1'b1;

        // Request held from cycle 0 with a granted read of 0x100 and full
        // byte-enable writes that must be suppressed until the grant.
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b1, 1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF);
        for (int i = 0; i < 14; i++) drive_cycle(1'b0, 1'b0, 1'b0, 4'h0, $urandom, $urandom);

        // Single-cycle request pulse.
        drive_cycle(1'b1, 1'b0, 1'b0, 4'h0, $urandom, $urandom);
        for (int i = 0; i < 12; i++) drive_cycle(1'b0, 1'b1, 1'b1, 4'hF, $urandom, $urandom);

        // Long held request: burst limiting or persistent grant.
        for (int i = 0; i < 130; i++)
            drive_cycle(1'b1, 1'($urandom), 1'b0, 4'h0, $urandom, $urandom);
        for (int i = 0; i < 12; i++) drive_cycle(1'b0, 1'b0, 1'b0, 4'h0, $urandom, $urandom);

        // Randomised traffic with sticky request behaviour.
        req_r = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(5) == 0) req_r = ~req_r;
            drive_cycle(req_r, 1'($urandom), 1'($urandom), 4'($urandom), $urandom, $urandom);
        end

        // Drive to a granted cycle, then pull reset between clock edges.
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b1, 4'hF, $urandom, $urandom);
            got = (last_role == R_GRANT);
        end
        if (!got) chk("grant_reached", 1'b0, 1'b1);
        @(negedge clk_i);
        #1;
        reset_n_i = 1'b0;
        #1;
        chk("async_halt", cpu_halt_o, 1'b0);
        chk("async_gnt", ext_gnt_o, 1'b0);
        chk("async_owner", owner_o, 1'b0);
        chk("async_rvalid", ext_rvalid_o, 1'b0);
        chk("async_bus_addr", bus_address_o, cpu_address_i);
        ext_req_i = 1'b0;
        ext_rd_i  = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("async_rdata", ext_rdata_o, '0);
        model_reset();
        #1 reset_n_i = 1'b1;

        // Arbitration restarts cleanly after reset.
        for (int i = 0; i < 6; i++) drive_cycle(1'b1, 1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'h0BAD_F00D);
        for (int i = 0; i < 6; i++) drive_cycle(1'b0, 1'b0, 1'b0, 4'h0, $urandom, $urandom);

        @(negedge clk_i);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cpu_bus_arbiter.md
CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; clk_i is the clock and reset_n_i is the reset.
REQ-002 Parameters SHALL be:
- address_width, 32: bus address width.
- data_width, 32: bus data width.
- SettleCycles, 2: halt-to-grant delay in cycles (1..15).
- MaxBurst, 64: maximum external-ownership cycles (1..65535).
- CpuMinCycles, 8: guaranteed CPU cycles after a release (0..255).
REQ-003 Ports SHALL be:
- clk_i  in  1  clock.
- reset_n_i  in  1  async active-low reset.
- cpu_address_i  in  address_width  CPU address.
- cpu_data_i  in  data_width  CPU write data.
- cpu_we_i  in  1  CPU peripheral write.
- cpu_we_ram_i  in  4  CPU RAM byte enables.
- cpu_halt_o  out  1  CPU stall.
- ext_req_i  in  1  external master bus request.
- ext_gnt_o  out  1  grant to external master.
- ext_address_i  in  address_width  external address.
- ext_data_i  in  data_width  external write data.
- ext_we_i  in  1  external peripheral write.
- ext_we_ram_i  in  4  external RAM byte enables.
- ext_rd_i  in  1  external read strobe.
- ext_rdata_o  out  data_width  read data to the external master.
- ext_rvalid_o  out  1  read data valid.
- bus_address_o  out  address_width  shared bus address.
- bus_data_o  out  data_width  shared bus write data.
- bus_we_o  out  1  shared bus peripheral write.
- bus_we_ram_o  out  4  shared bus RAM byte enables.
- bus_rdata_i  in  data_width  muxed bus read data, registered, 1-cycle latency.
- owner_o  out  1  current bus owner, 0=CPU, 1=external.

Function
REQ-004 The FSM SHALL have four states: CPU_OWN, HALT_REQ, EXT_OWN, EXT_DRAIN.
REQ-005 In CPU_OWN the bus outputs SHALL pass the cpu_* inputs combinationally; cpu_halt_o=0, ext_gnt_o=0, owner_o=0.
REQ-006 CPU_OWN SHALL move to HALT_REQ when ext_req_i=1 and the cooldown counter is 0.
REQ-007 In HALT_REQ: cpu_halt_o=1, bus_we_o=0, bus_we_ram_o=0, bus_address_o holds the last CPU address; after exactly SettleCycles cycles the FSM SHALL move to EXT_OWN.
REQ-008 In EXT_OWN: cpu_halt_o=1, ext_gnt_o=1, owner_o=1, and the bus outputs pass the ext_* inputs.
REQ-009 In EXT_OWN the burst counter SHALL increment every cycle, starting from 0 on entry.
REQ-010 EXT_OWN SHALL move to EXT_DRAIN when ext_req_i=0, or when the forced-release condition of REQ-018 holds.
REQ-011 In EXT_DRAIN: ext_gnt_o=0, cpu_halt_o=1, bus writes forced to 0; after one cycle the FSM SHALL move to CPU_OWN and load the cooldown counter with CpuMinCycles.
REQ-012 The cooldown counter SHALL decrement once per CPU_OWN cycle, saturating at 0.
REQ-013 ext_rvalid_o SHALL be 1 exactly one cycle after a cycle with ext_gnt_o=1 and ext_rd_i=1, with ext_rdata_o=bus_rdata_i in that cycle; this includes a read issued in the last EXT_OWN cycle, whose data returns in EXT_DRAIN.
REQ-014 ext_rd_i, ext_we_i and ext_we_ram_i SHALL be ignored while ext_gnt_o=0: no bus write and no rvalid.
REQ-015 If ext_req_i drops during HALT_REQ, the FSM SHALL still complete the settle count, enter EXT_OWN for one cycle, then go to EXT_DRAIN.
REQ-016 ext_rdata_o SHALL hold its last value while ext_rvalid_o=0.

Reset
REQ-017 While reset_n_i=0, asynchronously:
- state=CPU_OWN; all counters=0.
- cpu_halt_o=0, ext_gnt_o=0, ext_rvalid_o=0, ext_rdata_o=0, owner_o=0.
- Bus outputs follow the cpu_* inputs.
- A reset in any state SHALL abort external ownership immediately, with no drain cycle.

Configuration
REQ-018 Macro ARB_BURST_LIMIT_EN:
- Defined: EXT_OWN SHALL also exit when the burst counter reaches MaxBurst-1, giving at most MaxBurst grant cycles. A still-asserted ext_req_i is then re-served only after the cooldown.
- Undefined: no burst limit; the burst counter is not built, and ownership ends only when ext_req_i drops.

Structure
REQ-019 The arbiter state enum and the default SettleCycles/MaxBurst/CpuMinCycles localparams SHALL live in cpu_reg_package.
REQ-020 The block SHALL be a single module with no sub-module; the bus mux is an always_comb keyed on state.

Verification
REQ-021 Reset, then ext_req_i=1 at cycle 0: cpu_halt_o=1 at cycle 1, ext_gnt_o=1 at cycle 3 (SettleCycles=2), and bus_address_o equals ext_address_i from cycle 3.
REQ-022 Granted read at 0x0000_0100 with bus_rdata_i=0xDEADBEEF on the next cycle: ext_rvalid_o=1 for exactly one cycle with ext_rdata_o=0xDEADBEEF.
REQ-023 Write with ext_we_ram_i=4'hF before grant: bus_we_ram_o stays 0. After grant: bus_we_ram_o=4'hF in the same cycle.
REQ-024 With ARB_BURST_LIMIT_EN, MaxBurst=4 and ext_req_i held high: exactly 4 grant cycles, 1 drain cycle, then 8 cycles with cpu_halt_o=0, then a re-grant sequence. Without the macro: the grant persists 100+ cycles.
REQ-025 Assert reset_n_i=0 mid-EXT_OWN: cpu_halt_o and ext_gnt_o go to 0 in the same cycle, without a clock edge.
REQ-026 ext_req_i pulsed for 1 cycle: full sequence HALT_REQ(2) → EXT_OWN(1) → EXT_DRAIN(1) → CPU_OWN, with no bus write.
